// File: rtl/bcp_pkg.sv
// ---------------------------------------------------------------------------
// bcp_pkg
// Shared definitions for the BCP clause scanner:
//   - scan_state_t : scanner FSM states (IDLE/FETCH/EVAL/DONE)
//   - DEF_ADDRESS_WIDTH / DEF_VAR_NUM : default var_table geometry
//   - popcount_sat2 : population count that saturates at 2 (0, 1, "2 or more")
// ---------------------------------------------------------------------------
package bcp_pkg;

    localparam int DEF_ADDRESS_WIDTH = 3;
    localparam int DEF_VAR_NUM       = 8;

    // Widest clause row popcount_sat2 accepts; narrower rows are zero-extended.
    localparam int MAX_VARS = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EVAL  = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_t;

    // Unit detection only needs to tell 0, 1 and "more than one" apart,
    // so the count stops at 2.
    function automatic logic [1:0] popcount_sat2(input logic [MAX_VARS-1:0] v);
        logic [1:0] cnt;
        cnt = 2'd0;
        for (int i = 0; i < MAX_VARS; i++) begin
            if (v[i] && (cnt != 2'd2)) begin
                cnt = cnt + 2'd1;
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/bcp_clause_eval.sv
// ---------------------------------------------------------------------------
// bcp_clause_eval
// Combinational evaluation of one clause row against an assignment snapshot.
// Row bit i set means the clause contains the positive literal of variable i.
// Ports:
//   i_row       clause row from var_table
//   i_mask      1 = variable assigned
//   i_val       assigned value (meaningful where i_mask=1)
//   o_sat       some literal of the clause is true
//   o_unit      clause not satisfied and exactly one literal unassigned
//   o_conflict  clause not satisfied and no literal unassigned
//   o_unit_var  one-hot implied variable when o_unit=1, else 0
// An all-zero row is an empty slot: never unit, never conflict.
// ---------------------------------------------------------------------------
module bcp_clause_eval
    import bcp_pkg::*;
#(
    parameter int VAR_NUM = DEF_VAR_NUM
) (
    input  logic [VAR_NUM-1:0] i_row,
    input  logic [VAR_NUM-1:0] i_mask,
    input  logic [VAR_NUM-1:0] i_val,
    output logic               o_sat,
    output logic               o_unit,
    output logic               o_conflict,
    output logic [VAR_NUM-1:0] o_unit_var
);

    logic [VAR_NUM-1:0] w_unassigned;
    logic [1:0]         w_free;
    logic               w_empty;

    assign w_empty      = (i_row == '0);
    assign w_unassigned = i_row & ~i_mask;
    assign w_free       = popcount_sat2(MAX_VARS'(w_unassigned));

    assign o_sat      = |(i_row & i_mask & i_val);
    assign o_unit     = !w_empty && !o_sat && (w_free == 2'd1);
    assign o_conflict = !w_empty && !o_sat && (w_free == 2'd0);
    // With exactly one free literal the unassigned vector is already one-hot.
    assign o_unit_var = o_unit ? w_unassigned : '0;

endmodule

// File: rtl/bcp_clause_scanner.sv
// ---------------------------------------------------------------------------
// bcp_clause_scanner
// Scans var_table rows 0..CLAUSE_NUM-1 against a snapshot of the current
// assignment, accumulating implied variables and the first conflicting clause.
// Two cycles per row (FETCH issues the read, EVAL consumes the data).
// Optional build macro: CONFLICT_EARLY_EXIT_EN -- stop the scan at the first
// conflicting row instead of reading the remaining rows.
// Ports:
//   i_clock, i_reset (async, active-low)
//   i_start                  begin scan (honoured only in IDLE)
//   i_assign_mask/_val       current assignment, snapshotted at start
//   o_tbl_en/_r_w/_address/_din, i_tbl_dout   var_table read port
//   o_busy, o_done           status; o_done is a one-cycle pulse
//   o_conflict/_addr         first fully falsified clause
//   o_imply_mask             OR of all implied variables (implied value 1)
//   o_unit_count             number of unit clauses found
// ---------------------------------------------------------------------------
module bcp_clause_scanner
    import bcp_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int VAR_NUM       = DEF_VAR_NUM,
    parameter int CLAUSE_NUM    = 8
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_start,
    input  logic [VAR_NUM-1:0]       i_assign_mask,
    input  logic [VAR_NUM-1:0]       i_assign_val,
    output logic                     o_tbl_en,
    output logic                     o_tbl_r_w,
    output logic [ADDRESS_WIDTH-1:0] o_tbl_address,
    output logic [VAR_NUM-1:0]       o_tbl_din,
    input  logic [VAR_NUM-1:0]       i_tbl_dout,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_conflict,
    output logic [ADDRESS_WIDTH-1:0] o_conflict_addr,
    output logic [VAR_NUM-1:0]       o_imply_mask,
    output logic [ADDRESS_WIDTH:0]   o_unit_count
);

    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(CLAUSE_NUM - 1);

    scan_state_t              r_state;
    logic [VAR_NUM-1:0]       r_mask;
    logic [VAR_NUM-1:0]       r_val;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic                     r_tbl_en;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_conflict;
    logic [ADDRESS_WIDTH-1:0] r_conflict_addr;
    logic [VAR_NUM-1:0]       r_imply_mask;
    logic [ADDRESS_WIDTH:0]   r_unit_count;

    logic                     w_sat;
    logic                     w_unit;
    logic                     w_conflict;
    logic [VAR_NUM-1:0]       w_unit_var;
    logic                     w_first_conflict;

    bcp_clause_eval #(
        .VAR_NUM (VAR_NUM)
    ) u_eval (
        .i_row      (i_tbl_dout),
        .i_mask     (r_mask),
        .i_val      (r_val),
        .o_sat      (w_sat),
        .o_unit     (w_unit),
        .o_conflict (w_conflict),
        .o_unit_var (w_unit_var)
    );

    assign w_first_conflict = !w_sat && w_conflict && !r_conflict;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state         <= ST_IDLE;
            r_mask          <= '0;
            r_val           <= '0;
            r_addr          <= '0;
            r_tbl_en        <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_conflict      <= 1'b0;
            r_conflict_addr <= '0;
            r_imply_mask    <= '0;
            r_unit_count    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_mask          <= i_assign_mask;
                        r_val           <= i_assign_val;
                        r_conflict      <= 1'b0;
                        r_conflict_addr <= '0;
                        r_imply_mask    <= '0;
                        r_unit_count    <= '0;
                        r_addr          <= '0;
                        r_busy          <= 1'b1;
                        r_tbl_en        <= 1'b1;
                        r_state         <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    // var_table samples the address at this edge; data is
                    // on i_tbl_dout during EVAL.
                    r_tbl_en <= 1'b0;
                    r_state  <= ST_EVAL;
                end
                ST_EVAL: begin
                    if (!w_sat && w_unit) begin
                        r_imply_mask <= r_imply_mask | w_unit_var;
                        r_unit_count <= r_unit_count + 1'b1;
                    end
                    if (w_first_conflict) begin
                        r_conflict      <= 1'b1;
                        r_conflict_addr <= r_addr;
                    end
`ifdef CONFLICT_EARLY_EXIT_EN
                    if (w_first_conflict || (r_addr == LAST_ADDR)) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_addr   <= r_addr + 1'b1;
                        r_tbl_en <= 1'b1;
                        r_state  <= ST_FETCH;
                    end
`else
                    if (r_addr == LAST_ADDR) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_addr   <= r_addr + 1'b1;
                        r_tbl_en <= 1'b1;
                        r_state  <= ST_FETCH;
                    end
`endif
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_tbl_en        = r_tbl_en;
    assign o_tbl_r_w       = r_tbl_en;   // only ever reads
    assign o_tbl_address   = r_addr;
    assign o_tbl_din       = '0;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_conflict      = r_conflict;
    assign o_conflict_addr = r_conflict_addr;
    assign o_imply_mask    = r_imply_mask;
    assign o_unit_count    = r_unit_count;

endmodule

// File: tb/tb_bcp_clause_scanner.sv
// ---------------------------------------------------------------------------
// tb_bcp_clause_scanner
// Directed test of bcp_clause_scanner against a small var_table model holding
// rows 0..3 = 1110_0000, 1001_0000, 0100_1000, 0001_1000 and rows 4..7 = 0.
// Expected results depend on whether CONFLICT_EARLY_EXIT_EN is defined.
// ---------------------------------------------------------------------------
module tb_bcp_clause_scanner;

    localparam int AW = 3;
    localparam int VN = 8;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [VN-1:0] assign_mask;
    logic [VN-1:0] assign_val;
    logic          tbl_en;
    logic          tbl_r_w;
    logic [AW-1:0] tbl_address;
    logic [VN-1:0] tbl_din;
    logic [VN-1:0] tbl_dout;
    logic          busy;
    logic          done;
    logic          conflict;
    logic [AW-1:0] conflict_addr;
    logic [VN-1:0] imply_mask;
    logic [AW:0]   unit_count;

    int checks = 0;
    int errors = 0;

    bcp_clause_scanner #(
        .ADDRESS_WIDTH (AW),
        .VAR_NUM       (VN),
        .CLAUSE_NUM    (8)
    ) dut (
        .i_clock         (clk),
        .i_reset         (rst_n),
        .i_start         (start),
        .i_assign_mask   (assign_mask),
        .i_assign_val    (assign_val),
        .o_tbl_en        (tbl_en),
        .o_tbl_r_w       (tbl_r_w),
        .o_tbl_address   (tbl_address),
        .o_tbl_din       (tbl_din),
        .i_tbl_dout      (tbl_dout),
        .o_busy          (busy),
        .o_done          (done),
        .o_conflict      (conflict),
        .o_conflict_addr (conflict_addr),
        .o_imply_mask    (imply_mask),
        .o_unit_count    (unit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // var_table model: registered read, data valid the cycle after the address.
    logic [VN-1:0] mem [0:7];
    initial begin
        mem[0] = 8'b1110_0000;
        mem[1] = 8'b1001_0000;
        mem[2] = 8'b0100_1000;
        mem[3] = 8'b0001_1000;
        mem[4] = 8'h00;
        mem[5] = 8'h00;
        mem[6] = 8'h00;
        mem[7] = 8'h00;
        tbl_dout = '0;
    end
    always @(posedge clk) begin
        if (tbl_en) tbl_dout <= mem[tbl_address];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        string         name;
        logic [VN-1:0] mask;
        logic [VN-1:0] val;
        logic [VN-1:0] exp_imply;
        int            exp_units;
        logic          exp_conf;
        int            exp_caddr;
        int            exp_lat;
        int            exp_reads;
    } vec_t;

    vec_t vecs [5];

    // Runs one scan. Start is accepted at edge E0; lat = edges after E0 until
    // done is seen. Reads must hit addresses 0,1,2,... in order with r_w=1,
    // din=0. If extra_k >= 0, a spurious start plus an assignment change is
    // applied around that point in the scan.
    task automatic run_scan(input logic [VN-1:0] m, input logic [VN-1:0] v, input int extra_k,
                            output int lat, output int nreads, output int bad_reads,
                            output int done_len);
        int k;
        @(negedge clk);
        assign_mask = m;
        assign_val  = v;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        lat       = -1;
        nreads    = 0;
        bad_reads = 0;
        done_len  = 0;
        for (k = 0; k < 60; k++) begin
            if (k == extra_k) begin
                start       = 1'b1;
                assign_mask = ~m;
                assign_val  = ~v;
            end else if (k == extra_k + 1) begin
                start = 1'b0;
            end
            if (tbl_en) begin
                if (tbl_address != AW'(nreads) || tbl_r_w !== 1'b1 || tbl_din !== '0)
                    bad_reads++;
                nreads++;
            end
            if (done) begin
                lat = k;
                break;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        // measure pulse width
        while (done && done_len < 5) begin
            done_len++;
            @(posedge clk);
            #1;
        end
    endtask

    int lat, nreads, bad_reads, done_len, ndone;

    initial begin
        start       = 1'b0;
        assign_mask = '0;
        assign_val  = '0;
        rst_n       = 1'b0;

`ifdef CONFLICT_EARLY_EXIT_EN
        vecs[0] = '{"unassigned", 8'h00, 8'h00, 8'h00,        0, 1'b0, 0, 17, 8};
        vecs[1] = '{"two_false",  8'hC0, 8'h00, 8'b0011_1000, 3, 1'b0, 0, 17, 8};
        vecs[2] = '{"conf_row0",  8'hE0, 8'h00, 8'h00,        0, 1'b1, 0, 3,  1};
        vecs[3] = '{"sat_rows",   8'h80, 8'h80, 8'h00,        0, 1'b0, 0, 17, 8};
        vecs[4] = '{"conf_row3",  8'h18, 8'h00, 8'b1100_0000, 2, 1'b1, 3, 9,  4};
`else
        vecs[0] = '{"unassigned", 8'h00, 8'h00, 8'h00,        0, 1'b0, 0, 17, 8};
        vecs[1] = '{"two_false",  8'hC0, 8'h00, 8'b0011_1000, 3, 1'b0, 0, 17, 8};
        vecs[2] = '{"conf_row0",  8'hE0, 8'h00, 8'b0001_1000, 2, 1'b1, 0, 17, 8};
        vecs[3] = '{"sat_rows",   8'h80, 8'h80, 8'h00,        0, 1'b0, 0, 17, 8};
        vecs[4] = '{"conf_row3",  8'h18, 8'h00, 8'b1100_0000, 2, 1'b1, 3, 17, 8};
`endif

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_tbl_en", 32'(tbl_en), 32'd0);
        chk("rst_results", 32'({conflict, conflict_addr, imply_mask, unit_count, tbl_address}), 32'd0);
        $display("reset: busy=%0b done=%0b tbl_en=%0b", busy, done, tbl_en);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven scans
        for (int i = 0; i < 5; i++) begin
            run_scan(vecs[i].mask, vecs[i].val, -1, lat, nreads, bad_reads, done_len);
            $display("scan %s: mask=%b val=%b imply=%b units=%0d conflict=%0b caddr=%0d lat=%0d reads=%0d",
                     vecs[i].name, vecs[i].mask, vecs[i].val, imply_mask, unit_count,
                     conflict, conflict_addr, lat, nreads);
            chk({vecs[i].name, "_imply"},    32'(imply_mask),    32'(vecs[i].exp_imply));
            chk({vecs[i].name, "_units"},    32'(unit_count),    32'(vecs[i].exp_units));
            chk({vecs[i].name, "_conflict"}, 32'(conflict),      32'(vecs[i].exp_conf));
            chk({vecs[i].name, "_caddr"},    32'(conflict_addr), 32'(vecs[i].exp_caddr));
            chk({vecs[i].name, "_latency"},  32'(lat),           32'(vecs[i].exp_lat));
            chk({vecs[i].name, "_reads"},    32'(nreads),        32'(vecs[i].exp_reads));
            chk({vecs[i].name, "_read_seq"}, 32'(bad_reads),     32'd0);
            chk({vecs[i].name, "_done_len"}, 32'(done_len),      32'd1);
            chk({vecs[i].name, "_busy_end"}, 32'(busy),          32'd0);
        end

        // All-false assignment: every populated row conflicts, first one wins.
        run_scan(8'hFF, 8'h00, -1, lat, nreads, bad_reads, done_len);
        $display("scan all_false: conflict=%0b caddr=%0d units=%0d lat=%0d", conflict, conflict_addr, unit_count, lat);
        chk("all_false_conflict", 32'(conflict), 32'd1);
        chk("all_false_caddr", 32'(conflict_addr), 32'd0);
        chk("all_false_units", 32'(unit_count), 32'd0);

        // Results hold after done
        repeat (4) @(posedge clk);
        #1;
        chk("hold_conflict", 32'(conflict), 32'd1);
        chk("hold_caddr", 32'(conflict_addr), 32'd0);

        // Start and assignment changes mid-scan are ignored
        run_scan(8'hC0, 8'h00, 4, lat, nreads, bad_reads, done_len);
        $display("scan midstart: imply=%b units=%0d conflict=%0b lat=%0d", imply_mask, unit_count, conflict, lat);
        chk("midstart_imply", 32'(imply_mask), 32'(8'b0011_1000));
        chk("midstart_units", 32'(unit_count), 32'd3);
        chk("midstart_conflict", 32'(conflict), 32'd0);
        chk("midstart_latency", 32'(lat), 32'd17);

        // Reset five cycles into a scan: immediate clear, no done pulse
        @(negedge clk);
        assign_mask = 8'hC0;
        assign_val  = 8'h00;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        $display("midscan reset: busy=%0b tbl_en=%0b imply=%b units=%0d", busy, tbl_en, imply_mask, unit_count);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_tbl_en", 32'(tbl_en), 32'd0);
        chk("abort_results", 32'({conflict, conflict_addr, imply_mask, unit_count, tbl_address, done}), 32'd0);
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);

        // Fresh scan after reset
        run_scan(8'h00, 8'h00, -1, lat, nreads, bad_reads, done_len);
        $display("scan after_reset: imply=%b units=%0d lat=%0d reads=%0d", imply_mask, unit_count, lat, nreads);
        chk("post_rst_latency", 32'(lat), 32'd17);
        chk("post_rst_reads", 32'(nreads), 32'd8);
        chk("post_rst_imply", 32'(imply_mask), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
